// File: rtl/cache_def.sv
// Shared types for the cache-to-memory line interface.
package cache_def;

    localparam int MEM_LINE_W = 128;

    typedef struct packed {
        logic [31:0]           addr;
        logic [MEM_LINE_W-1:0] data;
        logic                  rw;     // 1 = write
        logic                  valid;
    } mem_req_type;

    typedef struct packed {
        logic [MEM_LINE_W-1:0] data;
        logic                  ready;
    } mem_data_type;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_type;

endpackage

// File: rtl/mem_line_array.sv
// Line store: synchronous write, combinational read, contents survive reset.
module mem_line_array
    import cache_def::*;
#(
    parameter int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [MEM_LINE_W-1:0] wdata_i,
    output logic [MEM_LINE_W-1:0] rdata_o
);

    logic [MEM_LINE_W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_reg[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_reg[idx_i];

endmodule

// File: rtl/mem_line_responder.sv
// Backing-memory responder: completes one line read/write per request after a
// fixed latency and signals completion with a single-cycle ready pulse.
module mem_line_responder
    import cache_def::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  mem_req_type  mem_req_i,
    output mem_data_type mem_data_o,
    output logic         busy_o,
    output logic [31:0]  no_rd_o,
    output logic [31:0]  no_wr_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    resp_state_type        state_reg, state_next;
    logic [7:0]            cnt_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  rw_reg;
    logic [MEM_LINE_W-1:0] wdata_reg;
    logic [MEM_LINE_W-1:0] data_reg;
    logic [31:0]           no_rd_reg;
    logic [31:0]           no_wr_reg;

    logic [IDX_W-1:0]      req_idx;
    logic                  accept;
    logic                  enter_resp;
    logic [IDX_W-1:0]      op_idx;
    logic                  op_rw;
    logic [MEM_LINE_W-1:0] op_wdata;
    logic                  store_we;
    logic [MEM_LINE_W-1:0] store_rdata;
    logic                  unused_addr_bits;

    assign req_idx          = mem_req_i.addr[4+IDX_W-1:4];
    assign unused_addr_bits = ^{mem_req_i.addr[3:0], mem_req_i.addr[31:4+IDX_W]};
    assign accept           = (state_reg == IDLE) && mem_req_i.valid;
    assign enter_resp       = (state_reg != RESP) && (state_next == RESP);

    // With LATENCY==1 RESP is entered straight from IDLE, before the request
    // has been latched, so the live request fields drive the operation.
    assign op_idx   = (state_reg == IDLE) ? req_idx        : idx_reg;
    assign op_rw    = (state_reg == IDLE) ? mem_req_i.rw   : rw_reg;
    assign op_wdata = (state_reg == IDLE) ? mem_req_i.data : wdata_reg;
    assign store_we = rst_ni && enter_resp && op_rw;

    mem_line_array #(
        .DEPTH (MEM_DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (store_we),
        .idx_i   (op_idx),
        .wdata_i (op_wdata),
        .rdata_o (store_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (mem_req_i.valid) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 8'd1) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_data_o       = '0;
        mem_data_o.data  = data_reg;
        mem_data_o.ready = (state_reg == RESP);
        busy_o           = (state_reg != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_reg   <= '0;
            data_reg  <= '0;
            no_rd_reg <= '0;
            no_wr_reg <= '0;
        end else begin
            if (accept) begin
                cnt_reg <= CNT_INIT;
            end else if (state_reg == WAIT) begin
                cnt_reg <= cnt_reg - 8'd1;
            end
            if (enter_resp) begin
                if (op_rw) begin
                    no_wr_reg <= no_wr_reg + 32'd1;
                end else begin
                    data_reg  <= store_rdata;
                    no_rd_reg <= no_rd_reg + 32'd1;
                end
            end
        end
    end

    // Request payload needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            idx_reg   <= req_idx;
            rw_reg    <= mem_req_i.rw;
            wdata_reg <= mem_req_i.data;
        end
    end

    assign no_rd_o = no_rd_reg;
    assign no_wr_o = no_wr_reg;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: a LATENCY=4/1024-line instance and
// a LATENCY=1/16-line instance share one stimulus port selected by sel.
module tb_mem_line_responder;
    import cache_def::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sel;
    mem_req_type  req;
    mem_req_type  req0, req1;
    mem_data_type rsp0, rsp1;
    logic         busy0, busy1;
    logic [31:0]  nrd0, nwr0, nrd1, nwr1;

    assign req0 = sel ? '0 : req;
    assign req1 = sel ? req : '0;

    mem_line_responder #(.MEM_DEPTH(1024), .LATENCY(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req0), .mem_data_o(rsp0),
        .busy_o(busy0), .no_rd_o(nrd0), .no_wr_o(nwr0));

    mem_line_responder #(.MEM_DEPTH(16), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req1), .mem_data_o(rsp1),
        .busy_o(busy1), .no_rd_o(nrd1), .no_wr_o(nwr1));

    logic         rdy;
    logic [127:0] rdata;
    logic         busy;
    logic [31:0]  nrd, nwr;
    assign rdy   = sel ? rsp1.ready : rsp0.ready;
    assign rdata = sel ? rsp1.data  : rsp0.data;
    assign busy  = sel ? busy1 : busy0;
    assign nrd   = sel ? nrd1 : nrd0;
    assign nwr   = sel ? nwr1 : nwr0;

    typedef struct {
        int           cyc;
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model[int];
    logic [127:0] last_rd;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int ready_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat();
        return sel ? 1 : 4;
    endfunction

    function automatic int depth();
        return sel ? 16 : 1024;
    endfunction

    // Scoreboard: every ready pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        exp_t e;
        if (rdy) begin
            ready_cnt++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_spurious_ready cyc=%0d got ready=1 want no pulse", cyc);
            end else begin
                e = sb.pop_front();
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL sb_ready_cycle got cyc=%0d want cyc=%0d", cyc, e.cyc);
                end
                checks++;
                if (rdata !== e.data) begin
                    failures++;
                    $display("FAIL sb_data cyc=%0d got %h want %h", cyc, rdata, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic [127:0] d, input logic rw);
        exp_t e;
        int   key;
        key       = (sel ? 65536 : 0) + int'((addr >> 4) & (depth() - 1));
        req.addr  = addr;
        req.data  = d;
        req.rw    = rw;
        req.valid = 1'b1;
        e.cyc     = cyc + lat();
        if (rw) begin
            model[key] = d;
            e.data     = last_rd;
        end else begin
            e.data  = model.exists(key) ? model[key] : '0;
            last_rd = e.data;
        end
        sb.push_back(e);
        $display("txn sel=%0d cyc=%0d %s addr=%h data=%h", sel, cyc, rw ? "WR" : "RD", addr, d);
    endtask

    task automatic wait_ready(output int at);
        at = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rdy) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            failures++;
            $display("FAIL wait_ready_timeout cyc=%0d got no ready within 50 cycles", cyc);
        end
    endtask

    task automatic run_txn(input logic [31:0] addr, input logic [127:0] d, input logic rw);
        int at;
        issue(addr, d, rw);
        step();
        req.valid = 1'b0;
        wait_ready(at);
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) step();
        rst_n = 1'b1;
        sb.delete();
        last_rd = '0;
        step();
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        req = '{addr: 32'h20, data: {4{32'hDEAD_BEEF}}, rw: 1'b1, valid: 1'b1};
        repeat (3) step();
        rst_n = 1'b1;
        req.valid = 1'b0;
        sb.delete();
        last_rd = '0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got %b want 0", rdy); end
        checks++; if (rdata !== '0) begin failures++; $display("FAIL reset_data got %h want 0", rdata); end
        checks++; if (nrd !== 32'd0) begin failures++; $display("FAIL reset_no_rd got %0d want 0", nrd); end
        checks++; if (nwr !== 32'd0) begin failures++; $display("FAIL reset_no_wr got %0d want 0", nwr); end
        step();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_valid_accepted busy got %b want 0", busy); end
        step();
    endtask

    task automatic test_single_read();
        int at;
        sel = 1'b0;
        apply_reset();
        run_txn(32'h50, {16{8'hA5}}, 1'b1);
        issue(32'h50, '0, 1'b0);
        step();
        req.valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got %b want 1", busy); end
        wait_ready(at);
        step();
        @(negedge clk);
        checks++; if (rdata !== {16{8'hA5}}) begin failures++; $display("FAIL single_data_hold got %h want %h", rdata, {16{8'hA5}}); end
        checks++; if (nrd !== 32'd1) begin failures++; $display("FAIL single_no_rd got %0d want 1", nrd); end
        checks++; if (nwr !== 32'd1) begin failures++; $display("FAIL single_no_wr got %0d want 1", nwr); end
        step();
    endtask

    task automatic test_write_read();
        int r1, r2;
        sel = 1'b0;
        apply_reset();
        issue(32'h1230, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b1);
        step();
        wait_ready(r1);
        step();
        issue(32'h1238, '0, 1'b0);
        step();
        req.valid = 1'b0;
        wait_ready(r2);
        step();
        @(negedge clk);
        checks++; if (r2 - r1 !== 5) begin failures++; $display("FAIL wr_rd_spacing got %0d want 5", r2 - r1); end
        checks++; if (nrd !== 32'd1) begin failures++; $display("FAIL wr_rd_no_rd got %0d want 1", nrd); end
        checks++; if (nwr !== 32'd1) begin failures++; $display("FAIL wr_rd_no_wr got %0d want 1", nwr); end
        step();
    endtask

    task automatic test_back_to_back();
        int r1, r2, rc0;
        sel = 1'b0;
        apply_reset();
        rc0 = ready_cnt;
        issue(32'h70, {4{32'h1357_9BDF}}, 1'b1);
        step();
        wait_ready(r1);
        step();
        issue(32'h70, '0, 1'b0);
        step();
        wait_ready(r2);
        step();
        req.valid = 1'b0;
        repeat (12) step();
        @(negedge clk);
        checks++; if (ready_cnt - rc0 !== 2) begin failures++; $display("FAIL b2b_pulses got %0d want 2", ready_cnt - rc0); end
        checks++; if (nwr !== 32'd1) begin failures++; $display("FAIL b2b_no_wr got %0d want 1", nwr); end
        checks++; if (nrd !== 32'd1) begin failures++; $display("FAIL b2b_no_rd got %0d want 1", nrd); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got %b want 0", busy); end
        step();
    endtask

    task automatic test_latency1();
        int at, prev;
        sel = 1'b1;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            run_txn(32'(i) << 4, {4{32'hC0DE_0000 ^ 32'(i)}}, 1'b1);
        end
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            issue(32'(i) << 4, '0, 1'b0);
            step();
            wait_ready(at);
            if (i > 0) begin
                checks++;
                if (at - prev !== 2) begin failures++; $display("FAIL lat1_spacing read=%0d got %0d want 2", i, at - prev); end
            end
            prev = at;
            step();
        end
        req.valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks++; if (nrd !== 32'd8) begin failures++; $display("FAIL lat1_no_rd got %0d want 8", nrd); end
        checks++; if (nwr !== 32'd8) begin failures++; $display("FAIL lat1_no_wr got %0d want 8", nwr); end
        step();
    endtask

    task automatic test_alias();
        sel = 1'b1;
        apply_reset();
        run_txn(32'h0000_0010, {4{32'hA11A_5ED0}}, 1'b1);
        run_txn(32'h0000_0110, '0, 1'b0);
        @(negedge clk);
        checks++; if (rdata !== {4{32'hA11A_5ED0}}) begin failures++; $display("FAIL alias_data got %h want %h", rdata, {4{32'hA11A_5ED0}}); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [127:0] old_d;
        old_d = {4{32'h0DD0_0DD0}};
        sel = 1'b0;
        apply_reset();
        run_txn(32'h90, old_d, 1'b1);
        apply_reset();
        issue(32'h90, {4{32'hBAD0_BAD0}}, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        req.valid = 1'b0;
        step();
        void'(sb.pop_back());
        model[9] = old_d;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (nwr !== 32'd0) begin failures++; $display("FAIL midrst_no_wr got %0d want 0", nwr); end
        rst_n = 1'b1;
        repeat (8) step();
        run_txn(32'h90, '0, 1'b0);
        @(negedge clk);
        checks++; if (rdata !== old_d) begin failures++; $display("FAIL midrst_store got %h want %h", rdata, old_d); end
        checks++; if (nwr !== 32'd0) begin failures++; $display("FAIL midrst_no_wr_after got %0d want 0", nwr); end
        checks++; if (nrd !== 32'd1) begin failures++; $display("FAIL midrst_no_rd got %0d want 1", nrd); end
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        sel     = 1'b0;
        req     = '0;
        last_rd = '0;
        test_reset();
        test_single_read();
        test_write_read();
        test_back_to_back();
        test_latency1();
        test_alias();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover got %0d pending want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
